// File: rtl/div_share_arbiter_if.sv
// Requester and divider signal bundle for div_share_arbiter.
// slave = arbiter side; master = requesters plus the shared divider.
interface div_share_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CLZ_W      = $clog2(DATA_WIDTH)
);
  logic                  r0_start, r0_divisor_is_zero, r0_busy, r0_done;
  logic [DATA_WIDTH-1:0] r0_dividend, r0_divisor, r0_quotient, r0_remainder;
  logic [CLZ_W-1:0]      r0_dividend_CLZ, r0_divisor_CLZ;

  logic                  r1_start, r1_divisor_is_zero, r1_busy, r1_done;
  logic [DATA_WIDTH-1:0] r1_dividend, r1_divisor, r1_quotient, r1_remainder;
  logic [CLZ_W-1:0]      r1_dividend_CLZ, r1_divisor_CLZ;

  logic                  div_start, div_divisor_is_zero, div_done;
  logic [DATA_WIDTH-1:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic [CLZ_W-1:0]      div_dividend_CLZ, div_divisor_CLZ;

  modport slave (
    input  r0_start, r0_dividend, r0_dividend_CLZ, r0_divisor, r0_divisor_CLZ, r0_divisor_is_zero,
    output r0_busy, r0_done, r0_quotient, r0_remainder,
    input  r1_start, r1_dividend, r1_dividend_CLZ, r1_divisor, r1_divisor_CLZ, r1_divisor_is_zero,
    output r1_busy, r1_done, r1_quotient, r1_remainder,
    output div_start, div_dividend, div_dividend_CLZ, div_divisor, div_divisor_CLZ, div_divisor_is_zero,
    input  div_done, div_quotient, div_remainder
  );

  modport master (
    output r0_start, r0_dividend, r0_dividend_CLZ, r0_divisor, r0_divisor_CLZ, r0_divisor_is_zero,
    input  r0_busy, r0_done, r0_quotient, r0_remainder,
    output r1_start, r1_dividend, r1_dividend_CLZ, r1_divisor, r1_divisor_CLZ, r1_divisor_is_zero,
    input  r1_busy, r1_done, r1_quotient, r1_remainder,
    input  div_start, div_dividend, div_dividend_CLZ, div_divisor, div_divisor_CLZ, div_divisor_is_zero,
    output div_done, div_quotient, div_remainder
  );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one unsigned divider between two requesters.
// Optional: `define DIV_SHARE_ARB_ZERO_BYPASS_EN answers divide-by-zero locally without the divider.
module div_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CLZ_W      = $clog2(DATA_WIDTH)
) (
  input logic                clk,
  input logic                rst_n,
  div_share_arbiter_if.slave bus
);

`ifdef DIV_SHARE_ARB_ZERO_BYPASS_EN
  localparam logic ZERO_BYPASS = 1'b1;
`else
  localparam logic ZERO_BYPASS = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  logic [1:0]            w_start, w_dz;
  logic [DATA_WIDTH-1:0] w_dvd     [2];
  logic [DATA_WIDTH-1:0] w_dvs     [2];
  logic [CLZ_W-1:0]      w_dvd_clz [2];
  logic [CLZ_W-1:0]      w_dvs_clz [2];

  assign w_start      = {bus.r1_start, bus.r0_start};
  assign w_dz         = {bus.r1_divisor_is_zero, bus.r0_divisor_is_zero};
  assign w_dvd[0]     = bus.r0_dividend;
  assign w_dvd[1]     = bus.r1_dividend;
  assign w_dvs[0]     = bus.r0_divisor;
  assign w_dvs[1]     = bus.r1_divisor;
  assign w_dvd_clz[0] = bus.r0_dividend_CLZ;
  assign w_dvd_clz[1] = bus.r1_dividend_CLZ;
  assign w_dvs_clz[0] = bus.r0_divisor_CLZ;
  assign w_dvs_clz[1] = bus.r1_divisor_CLZ;

  state_t                r_state, w_nxt;
  logic                  r_own, r_ptr;
  logic [1:0]            r_vld, r_byp, r_dz;
  logic [DATA_WIDTH-1:0] r_dvd     [2];
  logic [DATA_WIDTH-1:0] r_dvs     [2];
  logic [CLZ_W-1:0]      r_dvd_clz [2];
  logic [CLZ_W-1:0]      r_dvs_clz [2];
  logic [DATA_WIDTH-1:0] r_q       [2];
  logic [DATA_WIDTH-1:0] r_r       [2];

  logic                  w_issue, w_fin, w_gnt, w_sel, w_drive;
  logic [1:0]            w_busy, w_accept, w_bypass, w_capture, w_fin_n, w_done;
  logic [DATA_WIDTH-1:0] w_q [2];
  logic [DATA_WIDTH-1:0] w_r [2];

  // A start on a busy slot is a protocol violation and is dropped.
  assign w_busy    = r_vld | r_byp;
  assign w_accept  = w_start & ~w_busy;
  assign w_bypass  = w_accept & w_dz & {2{ZERO_BYPASS}};
  assign w_capture = w_accept & ~w_bypass;

  always_comb begin
    w_nxt   = r_state;
    w_issue = 1'b0;
    w_fin   = 1'b0;
    w_gnt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_vld) begin
          w_issue = 1'b1;
          w_gnt   = (r_vld == 2'b11) ? r_ptr : r_vld[1];
          w_nxt   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.div_done) begin
          w_fin = 1'b1;
          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_fin_n[n] = w_fin && (r_own == 1'(n));
      w_done[n]  = w_fin_n[n] | r_byp[n];
      w_q[n]     = w_fin_n[n] ? bus.div_quotient  : r_q[n];
      w_r[n]     = w_fin_n[n] ? bus.div_remainder : r_r[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_own   <= 1'b0;
      r_ptr   <= 1'b0;
      r_vld   <= '0;
      r_byp   <= '0;
    end else begin
      r_state <= w_nxt;
      r_byp   <= w_bypass;
      if (w_issue) begin
        r_own <= w_gnt;
        r_ptr <= ~w_gnt;
      end
      for (int n = 0; n < 2; n++) begin
        if (w_fin_n[n])        r_vld[n] <= 1'b0;
        else if (w_capture[n]) r_vld[n] <= 1'b1;
      end
    end
  end

  // Slot payload is only observed while its valid bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (w_capture[n]) begin
        r_dvd[n]     <= w_dvd[n];
        r_dvs[n]     <= w_dvs[n];
        r_dvd_clz[n] <= w_dvd_clz[n];
        r_dvs_clz[n] <= w_dvs_clz[n];
        r_dz[n]      <= w_dz[n];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        r_q[n] <= '0;
        r_r[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_fin_n[n]) begin
          r_q[n] <= bus.div_quotient;
          r_r[n] <= bus.div_remainder;
        end else if (w_bypass[n]) begin
          r_q[n] <= '1;
          r_r[n] <= w_dvd[n];
        end
      end
    end
  end

  // Operands follow the granted slot in the issue cycle, then the owner while busy.
  assign w_sel   = (r_state == S_BUSY) ? r_own : w_gnt;
  assign w_drive = w_issue | (r_state == S_BUSY);

  assign bus.div_start           = w_issue;
  assign bus.div_dividend        = w_drive ? r_dvd[w_sel]     : '0;
  assign bus.div_divisor         = w_drive ? r_dvs[w_sel]     : '0;
  assign bus.div_dividend_CLZ    = w_drive ? r_dvd_clz[w_sel] : '0;
  assign bus.div_divisor_CLZ     = w_drive ? r_dvs_clz[w_sel] : '0;
  assign bus.div_divisor_is_zero = w_drive & r_dz[w_sel];

  assign bus.r0_busy      = w_busy[0];
  assign bus.r1_busy      = w_busy[1];
  assign bus.r0_done      = w_done[0];
  assign bus.r1_done      = w_done[1];
  assign bus.r0_quotient  = w_q[0];
  assign bus.r1_quotient  = w_q[1];
  assign bus.r0_remainder = w_r[0];
  assign bus.r1_remainder = w_r[1];

endmodule
